// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM stage controller: datapath words, register indices, writeback select
// codes, MEM-FSM state encoding and the MEM/WB payload.
package mem_stage_ctrl_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned RDSEL_W = 3;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [REG_W-1:0]   regbits_t;
  typedef logic [RDSEL_W-1:0] rdsel_t;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_HALTED = 2'd2
  } memst_t;

  localparam rdsel_t RDSEL_ALU  = 3'd0;
  localparam rdsel_t RDSEL_LOAD = 3'd1;
  localparam rdsel_t RDSEL_LINK = 3'd2;
  localparam rdsel_t RDSEL_LUI  = 3'd3;

  typedef struct packed {
    logic     regWr;
    regbits_t rd;
    word_t    wdat;
    logic     halt;
  } mem_wb_t;

  // The dcache only takes word-aligned addresses.
  function automatic word_t word_align(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bus bundles around the MEM stage: the dcache request/response port and the MEM/WB latch outputs.
interface dcache_if;
  import mem_stage_ctrl_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (output dmemREN, output dmemWEN, output dmemaddr, output dmemstore,
                  input dhit, input dmemload);
  modport slave  (input dmemREN, input dmemWEN, input dmemaddr, input dmemstore,
                  output dhit, output dmemload);
endinterface

interface mem_wb_if;
  import mem_stage_ctrl_pkg::*;

  logic     wb_regWr;
  regbits_t wb_rd;
  word_t    wb_wdat;
  logic     wb_halt;

  modport master (output wb_regWr, output wb_rd, output wb_wdat, output wb_halt);
  modport slave  (input wb_regWr, input wb_rd, input wb_wdat, input wb_halt);
endinterface

// File: rtl/mem_stage_ctrl_wb_data_mux.sv
// Writeback source select; kept standalone so WB forwarding paths can share it.
module wb_data_mux
  import mem_stage_ctrl_pkg::*;
(
  input  rdsel_t rd_sel,
  input  word_t  alu_res,
  input  word_t  load_dat,
  input  word_t  link_dat,
  input  word_t  lui_dat,
  output word_t  wdat
);

  // Codes 4..7 are unused encodings and fall back to the ALU result.
  always_comb begin
    wdat = alu_res;
    case (rd_sel)
      RDSEL_LOAD: wdat = load_dat;
      RDSEL_LINK: wdat = link_dat;
      RDSEL_LUI:  wdat = lui_dat;
      default:    wdat = alu_res;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues dcache word accesses from the EX/MEM latch, stalls the front of
// the pipe until dhit, registers the MEM/WB fields and owns the sticky halt.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  dREN_i,
  input  logic                  dWEN_i,
  input  word_t                 addr_i,
  input  word_t                 store_i,
  input  word_t                 npc_i,
  input  word_t                 zeroExt_i,
  input  regbits_t              rd_i,
  input  logic                  regWr_i,
  input  rdsel_t                rdSel_i,
  input  logic                  halt_i,
  dcache_if.master              dc,
  mem_wb_if.master              wb,
  output logic                  mem_stall,
  output logic [WAIT_CNT_W-1:0] wait_cnt
);

  localparam logic [1:0] ST_IDLE   = MEM_IDLE;
  localparam logic [1:0] ST_ACCESS = MEM_ACCESS;
  localparam logic [1:0] ST_HALTED = MEM_HALTED;

  logic [1:0]            state_q, state_d;
  mem_wb_t               wb_q, wb_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic  req_c;
  logic  stall_c;
  word_t wdat_c;

  // A memory op in the latch is a live request unless halted or in reset.
  always_comb begin
    req_c   = (dREN_i | dWEN_i) & (state_q != ST_HALTED) & ~RST;
    stall_c = req_c & ~dc.dhit;
  end

  assign dc.dmemREN   = req_c & dREN_i;
  assign dc.dmemWEN   = req_c & dWEN_i & ~dREN_i;
  assign dc.dmemaddr  = req_c ? word_align(addr_i) : '0;
  assign dc.dmemstore = req_c ? store_i : '0;
  assign mem_stall    = stall_c;

  wb_data_mux u_wb_data_mux (
    .rd_sel   (rdSel_i),
    .alu_res  (addr_i),
    .load_dat (dc.dmemload),
    .link_dat (npc_i),
    .lui_dat  (zeroExt_i),
    .wdat     (wdat_c)
  );

  // Next-state, MEM/WB payload and stall counter.
  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    wait_cnt_d = wait_cnt_q;

    if (stall_c) begin
      wb_d.regWr = 1'b0;
      if (wait_cnt_q != '1) begin
        wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_ACCESS: begin
        if (stall_c) begin
          state_d = ST_ACCESS;
        end else begin
          wb_d.regWr = regWr_i;
          wb_d.rd    = rd_i;
          wb_d.wdat  = wdat_c;
          wb_d.halt  = wb_q.halt | halt_i;
          state_d    = halt_i ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: begin
        wb_d.regWr = 1'b0;
        wb_d.halt  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wb_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wb.wb_regWr = wb_q.regWr;
  assign wb.wb_rd    = wb_q.rd;
  assign wb.wb_wdat  = wb_q.wdat;
  assign wb.wb_halt  = wb_q.halt;
  assign wait_cnt    = wait_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scenario bench for mem_stage_ctrl: expected MEM/WB payloads are queued when an instruction
// is driven and compared when it retires; stall outputs are checked cycle by cycle.
module tb_mem_stage_ctrl;

  localparam int unsigned TB_W = 8;

  typedef struct packed {
    logic        regWr;
    logic [4:0]  rd;
    logic [31:0] wdat;
    logic        halt;
  } wb_t;

  logic            CLK;
  logic            RST;
  logic            dREN_i, dWEN_i, regWr_i, halt_i;
  logic [31:0]     addr_i, store_i, npc_i, zeroExt_i;
  logic [4:0]      rd_i;
  logic [2:0]      rdSel_i;
  logic            mem_stall;
  logic [TB_W-1:0] wait_cnt;

  dcache_if dc ();
  mem_wb_if wb ();

  mem_stage_ctrl #(.WAIT_CNT_W(TB_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .dREN_i    (dREN_i),
    .dWEN_i    (dWEN_i),
    .addr_i    (addr_i),
    .store_i   (store_i),
    .npc_i     (npc_i),
    .zeroExt_i (zeroExt_i),
    .rd_i      (rd_i),
    .regWr_i   (regWr_i),
    .rdSel_i   (rdSel_i),
    .halt_i    (halt_i),
    .dc        (dc.master),
    .wb        (wb.master),
    .mem_stall (mem_stall),
    .wait_cnt  (wait_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int  total = 0;
  int  bad   = 0;
  wb_t exp_q[$];
  wb_t exp_e;
  wb_t obs;

  task automatic bubble();
    dREN_i = 0; dWEN_i = 0; regWr_i = 0; halt_i = 0; rdSel_i = 3'd0; rd_i = 5'd0;
    addr_i = 32'h0; store_i = 32'h0; npc_i = 32'h0; zeroExt_i = 32'h0;
    dc.dhit = 0; dc.dmemload = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    bubble();
    RST = 1; dREN_i = 1;
    #1;
    total++;
    if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL reset_req: REN=%b stall=%b want 0 0", dc.dmemREN, mem_stall);
    end
    @(posedge CLK); #1;
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL reset_wb: got %h want 0", obs);
    end
    total++;
    if (wait_cnt !== '0) begin
      bad++; $display("FAIL reset_wait: got %0d want 0", wait_cnt);
    end
    @(negedge CLK);
    RST = 0; bubble();
    exp_q.delete();
  endtask

  task automatic test_alu_ops();
    logic [2:0]  sel[4]  = '{3'd0, 3'd2, 3'd3, 3'd6};
    logic [31:0] addr[4] = '{32'h1234, 32'hAAAA0000, 32'h1, 32'h77};
    logic [31:0] want[4] = '{32'h1234, 32'h400, 32'hBEEF0000, 32'h77};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bubble();
      rdSel_i = sel[i]; addr_i = addr[i]; npc_i = 32'h400; zeroExt_i = 32'hBEEF0000;
      rd_i = 5'(5 + i); regWr_i = 1;
      exp_q.push_back('{regWr: 1'b1, rd: 5'(5 + i), wdat: want[i], halt: 1'b0});
      #1;
      total++;
      if (mem_stall !== 1'b0 || dc.dmemREN !== 1'b0 || dc.dmemWEN !== 1'b0) begin
        bad++; $display("FAIL alu_nostall[%0d]: stall=%b REN=%b WEN=%b want 0", i, mem_stall,
                        dc.dmemREN, dc.dmemWEN);
      end
      @(posedge CLK); #1;
      exp_e = exp_q.pop_front();
      obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
      total++;
      if (obs !== exp_e) begin
        bad++; $display("FAIL alu_wb[%0d]: got %h want %h", i, obs, exp_e);
      end
    end
  endtask

  task automatic test_load_stall();
    @(negedge CLK);
    bubble();
    dREN_i = 1; addr_i = 32'h103; rdSel_i = 3'd1; rd_i = 5'd7; regWr_i = 1;
    dc.dmemload = 32'h0BADF00D;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd7, wdat: 32'hDEADBEEF, halt: 1'b0});
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (dc.dmemaddr !== 32'h100 || dc.dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
        bad++; $display("FAIL load_req[%0d]: addr=%h REN=%b stall=%b want 100 1 1", i,
                        dc.dmemaddr, dc.dmemREN, mem_stall);
      end
      @(posedge CLK); #1;
      total++;
      if (wb.wb_regWr !== 1'b0 || wait_cnt !== TB_W'(i + 1)) begin
        bad++; $display("FAIL load_bubble[%0d]: regWr=%b wait=%0d want 0 %0d", i, wb.wb_regWr,
                        wait_cnt, i + 1);
      end
      @(negedge CLK);
    end
    dc.dhit = 1; dc.dmemload = 32'hDEADBEEF;
    #1;
    total++;
    if (mem_stall !== 1'b0) begin
      bad++; $display("FAIL load_hit_stall: got %b want 0", mem_stall);
    end
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e) begin
      bad++; $display("FAIL load_wb: got %h want %h", obs, exp_e);
    end
    total++;
    if (wait_cnt !== TB_W'(3)) begin
      bad++; $display("FAIL load_wait: got %0d want 3", wait_cnt);
    end
  endtask

  task automatic test_store();
    @(negedge CLK);
    bubble();
    dWEN_i = 1; addr_i = 32'h200; store_i = 32'hA5A5A5A5; dc.dhit = 1; rd_i = 5'd2;
    exp_q.push_back('{regWr: 1'b0, rd: 5'd2, wdat: 32'h200, halt: 1'b0});
    #1;
    total++;
    if (dc.dmemWEN !== 1'b1 || dc.dmemREN !== 1'b0 || mem_stall !== 1'b0 ||
        dc.dmemstore !== 32'hA5A5A5A5 || dc.dmemaddr !== 32'h200) begin
      bad++; $display("FAIL store_req: WEN=%b REN=%b stall=%b data=%h addr=%h want 1 0 0 a5a5a5a5 200",
                      dc.dmemWEN, dc.dmemREN, mem_stall, dc.dmemstore, dc.dmemaddr);
    end
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e) begin
      bad++; $display("FAIL store_wb: got %h want %h", obs, exp_e);
    end
    // Both enables set: read wins.
    @(negedge CLK);
    bubble();
    dREN_i = 1; dWEN_i = 1; addr_i = 32'h300; dc.dhit = 1;
    #1;
    total++;
    if (dc.dmemREN !== 1'b1 || dc.dmemWEN !== 1'b0) begin
      bad++; $display("FAIL ren_wins: REN=%b WEN=%b want 1 0", dc.dmemREN, dc.dmemWEN);
    end
    // dhit with no request is ignored.
    @(negedge CLK);
    bubble();
    dc.dhit = 1;
    #1;
    total++;
    if (dc.dmemWEN !== 1'b0 || dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL idle_hit: WEN=%b REN=%b stall=%b want 0 0 0", dc.dmemWEN, dc.dmemREN,
                      mem_stall);
    end
    @(posedge CLK); #1;
    total++;
    if (wait_cnt !== TB_W'(3)) begin
      bad++; $display("FAIL idle_hit_wait: got %0d want 3", wait_cnt);
    end
  endtask

  task automatic test_rst_mid_access();
    @(negedge CLK);
    bubble();
    addr_i = 32'h55; rd_i = 5'd3; regWr_i = 1;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd3, wdat: 32'h55, halt: 1'b0});
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e) begin
      bad++; $display("FAIL rst_pre_wb: got %h want %h", obs, exp_e);
    end
    @(negedge CLK);
    bubble();
    dREN_i = 1; addr_i = 32'h400; rdSel_i = 3'd1; rd_i = 5'd4; regWr_i = 1;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd4, wdat: 32'h0, halt: 1'b0});
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1;
    #1;
    total++;
    if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL rst_drop: REN=%b stall=%b want 0 0", dc.dmemREN, mem_stall);
    end
    @(posedge CLK); #1;
    exp_q.delete();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== '0 || wait_cnt !== '0) begin
      bad++; $display("FAIL rst_clear: wb=%h wait=%0d want 0 0", obs, wait_cnt);
    end
    @(negedge CLK);
    RST = 0; bubble();
  endtask

  task automatic test_saturate();
    @(negedge CLK);
    bubble();
    dREN_i = 1; addr_i = 32'h800; rdSel_i = 3'd1; rd_i = 5'd11; regWr_i = 1;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd11, wdat: 32'hCAFE0001, halt: 1'b0});
    for (int i = 1; i <= (1 << TB_W) + 5; i++) begin
      @(posedge CLK); #1;
      if (i == 254) begin
        total++;
        if (wait_cnt !== TB_W'(254)) begin
          bad++; $display("FAIL sat_count: got %0d want 254", wait_cnt);
        end
      end
    end
    total++;
    if (wait_cnt !== '1 || mem_stall !== 1'b1) begin
      bad++; $display("FAIL sat_hold: wait=%0d stall=%b want %0d 1", wait_cnt, mem_stall,
                      (1 << TB_W) - 1);
    end
    @(negedge CLK);
    dc.dhit = 1; dc.dmemload = 32'hCAFE0001;
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e || wait_cnt !== '1) begin
      bad++; $display("FAIL sat_retire: wb=%h wait=%0d want %h %0d", obs, wait_cnt, exp_e,
                      (1 << TB_W) - 1);
    end
  endtask

  task automatic test_halt();
    @(negedge CLK);
    bubble();
    dREN_i = 1; halt_i = 1; addr_i = 32'h900; rdSel_i = 3'd1; rd_i = 5'd9; regWr_i = 1;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd9, wdat: 32'h11223344, halt: 1'b1});
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      total++;
      if (wb.wb_halt !== 1'b0 || wb.wb_regWr !== 1'b0) begin
        bad++; $display("FAIL halt_early[%0d]: halt=%b regWr=%b want 0 0", i, wb.wb_halt,
                        wb.wb_regWr);
      end
      @(negedge CLK);
    end
    dc.dhit = 1; dc.dmemload = 32'h11223344;
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e) begin
      bad++; $display("FAIL halt_wb: got %h want %h", obs, exp_e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bubble();
      dREN_i = 1; regWr_i = 1; rd_i = 5'd1; addr_i = 32'h44;
      #1;
      total++;
      if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
        bad++; $display("FAIL halted_req[%0d]: REN=%b stall=%b want 0 0", i, dc.dmemREN,
                        mem_stall);
      end
      @(posedge CLK); #1;
      total++;
      if (wb.wb_regWr !== 1'b0 || wb.wb_halt !== 1'b1 || wb.wb_wdat !== 32'h11223344) begin
        bad++; $display("FAIL halted_wb[%0d]: regWr=%b halt=%b wdat=%h want 0 1 11223344", i,
                        wb.wb_regWr, wb.wb_halt, wb.wb_wdat);
      end
    end
    @(negedge CLK);
    bubble();
    RST = 1;
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 0;
    addr_i = 32'h66; rd_i = 5'd6; regWr_i = 1;
    exp_q.push_back('{regWr: 1'b1, rd: 5'd6, wdat: 32'h66, halt: 1'b0});
    @(posedge CLK); #1;
    exp_e = exp_q.pop_front();
    obs = {wb.wb_regWr, wb.wb_rd, wb.wb_wdat, wb.wb_halt};
    total++;
    if (obs !== exp_e) begin
      bad++; $display("FAIL post_halt_reset: got %h want %h", obs, exp_e);
    end
  endtask

  initial begin
    RST = 1;
    bubble();
    test_reset();
    test_alu_ops();
    test_load_stall();
    test_store();
    test_rst_mid_access();
    test_saturate();
    test_halt();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
